// File: rtl/serial_mac_unit_if.sv
// ---------------------------------------------------------------------------
// serial_mac_unit_if
//   Start/done MAC handshake between a PID core (master, the initiator) and
//   its serial_mac_unit (slave, the responder).
//
//   Signals (all W bits wide unless noted; W = 2N of the MAC):
//     mul_start_strb  1  master -> slave  1-cycle start request
//     a               W  master -> slave  signed multiplicand
//     b               W  master -> slave  signed multiplier
//     acc             W  master -> slave  signed accumulate addend
//     mul_done_strb   1  slave -> master  1-cycle pulse, out is valid
//     out             W  slave -> master  a*b+acc, held until next completion
// ---------------------------------------------------------------------------
interface serial_mac_unit_if #(
    parameter int W = 82
);
    logic         mul_start_strb;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] acc;
    logic         mul_done_strb;
    logic [W-1:0] out;

    modport master (
        output mul_start_strb, a, b, acc,
        input  mul_done_strb, out
    );

    modport slave (
        input  mul_start_strb, a, b, acc,
        output mul_done_strb, out
    );
endinterface : serial_mac_unit_if

// File: rtl/serial_mac_unit.sv
// ---------------------------------------------------------------------------
// serial_mac_unit
//   Bit-serial multiply-accumulate responder: out = a*b + acc (mod 2^2N).
//   Shift-add over all 2N bits of the sign-extended multiplier, one step
//   every CLK_DIV_MULTIPLIER clocks. No DSP, one adder.
//
//   Parameters:
//     N                   operand base width; data paths are 2N bits
//     CLK_DIV_MULTIPLIER  clocks per shift-add step (>= 1)
//
//   Ports:
//     clk_i   in  clock, rising edge
//     rst_i   in  synchronous, active-high reset
//     mac     slave modport of serial_mac_unit_if (start/a/b/acc in,
//             done/out out)
//
//   Build option:
//     SERIAL_MAC_EARLY_TERM_EN  when defined, the operation finishes as soon
//                               as no set multiplier bits remain. Results are
//                               identical; only latency changes.
// ---------------------------------------------------------------------------
module serial_mac_unit #(
    parameter int N                  = 41,
    parameter int CLK_DIV_MULTIPLIER = 50
) (
    input  logic             clk_i,
    input  logic             rst_i,
    serial_mac_unit_if.slave mac
);
    localparam int W     = 2 * N;
    localparam int BIT_W = $clog2(W);
    localparam int DIV_W = $clog2(CLK_DIV_MULTIPLIER) + 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV_MULTIPLIER - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [W-1:0]     acc_r;
    logic [W-1:0]     mcand_r;
    logic [W-1:0]     mplier_r;
    logic [W-1:0]     out_r;
    logic             done_r;

    logic [W-1:0]     sum;
    logic             step_en;
    logic             last_step;

    // Partial product of the current multiplier bit added into the running sum.
    assign sum     = acc_r + (mplier_r[0] ? mcand_r : '0);
    assign step_en = (div_cnt == DIV_LAST);

`ifdef SERIAL_MAC_EARLY_TERM_EN
    // Finish once the bit being consumed is the last set one. A negative
    // multiplier keeps its sign-extended ones, so it still runs all 2N steps.
    assign last_step = (bit_cnt == BIT_LAST) || ((mplier_r >> 1) == '0);
`else
    assign last_step = (bit_cnt == BIT_LAST);
`endif

    assign mac.mul_done_strb = done_r;
    assign mac.out           = out_r;

    // NOTE: all state below is clocked, so it uses non-blocking assignments;
    // every register, including the wide work registers, is cleared by reset
    // so an aborted operation leaves no stale partial sum behind.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            out_r    <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (mac.mul_start_strb) begin
                        acc_r    <= mac.acc;
                        mcand_r  <= mac.a;
                        mplier_r <= mac.b;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    // Start requests are ignored here, including the cycle of
                    // the final step.
                    if (step_en) begin
                        div_cnt  <= '0;
                        acc_r    <= sum;
                        mcand_r  <= mcand_r << 1;
                        mplier_r <= mplier_r >> 1;
                        bit_cnt  <= bit_cnt + BIT_W'(1);
                        if (last_step) begin
                            out_r  <= sum;
                            done_r <= 1'b1;
                            state  <= IDLE;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule : serial_mac_unit

// File: tb/tb_serial_mac_unit.sv
// ---------------------------------------------------------------------------
// tb_serial_mac_unit
//   Self-checking bench for serial_mac_unit with N=4 (8-bit operands) and
//   CLK_DIV_MULTIPLIER=3. Expected results come from plain two's-complement
//   arithmetic; expected latency from the step count implied by b.
//   Honors SERIAL_MAC_EARLY_TERM_EN for the expected latency.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_mac_unit;
    localparam int N       = 4;
    localparam int W       = 2 * N;
    localparam int CDM     = 3;
    localparam int LAT_MAX = 40;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    serial_mac_unit_if #(.W(W)) mac ();

    serial_mac_unit #(.N(N), .CLK_DIV_MULTIPLIER(CDM)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .mac   (mac)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result: low W bits of a*b+acc, operands read as signed.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] acc);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b)) + longint'($signed(acc));
        return W'(p);
    endfunction

    // Reference latency in clocks from the start-sampling edge to the edge
    // after which done is high.
    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef SERIAL_MAC_EARLY_TERM_EN
        int msb;
        msb = 0;
        for (int i = 0; i < W; i++) if (b[i]) msb = i;
        return CDM * (msb + 1);
`else
        return CDM * W + 0 * int'(b[0]);
`endif
    endfunction

    // Called #1 after a clock edge. Asserts start so the next edge samples it,
    // then counts edges until done is seen (bounded).
    task automatic do_mac(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] acc, output logic [W-1:0] res,
                          output int lat);
        mac.mul_start_strb = 1'b1;
        mac.a   = a;
        mac.b   = b;
        mac.acc = acc;
        @(posedge clk_i);
        #1;
        mac.mul_start_strb = 1'b0;
        lat = 0;
        while (mac.mul_done_strb !== 1'b1 && lat < LAT_MAX) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        res = mac.out;
    endtask

    task automatic run_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] acc);
        logic [W-1:0] res;
        int           lat;
        do_mac(a, b, acc, res, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat(b)));
        check({tag, "_out"}, 32'(res), 32'(model(a, b, acc)));
        @(posedge clk_i);
        #1;
        check({tag, "_done_low"}, 32'(mac.mul_done_strb), 32'd0);
    endtask

    initial begin
        logic [W-1:0] res, chain, ra, rb, racc;
        int           lat, seen;

        mac.mul_start_strb = 1'b0;
        mac.a   = '0;
        mac.b   = '0;
        mac.acc = '0;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("rst_out", 32'(mac.out), 32'd0);
        check("rst_done", 32'(mac.mul_done_strb), 32'd0);

        // Directed arithmetic cases
        run_check("t1", 8'd3, 8'd5, 8'd2);
        check("t1_model", 32'(model(8'd3, 8'd5, 8'd2)), 32'h11);
        repeat (3) @(posedge clk_i);
        #1;
        check("t1_hold", 32'(mac.out), 32'h11);
        run_check("t2a", 8'hFD, 8'd5, 8'd0);
        check("t2a_val", 32'(mac.out), 32'hF1);
        run_check("t2b", 8'hFD, 8'hFB, 8'd0);
        check("t2b_val", 32'(mac.out), 32'h0F);
        run_check("t3", 8'd7, 8'd7, 8'h7F);
        check("t3_val", 32'(mac.out), 32'hB0);
        run_check("t6a", 8'd9, 8'd0, 8'h22);
        check("t6a_val", 32'(mac.out), 32'h22);

        // Start pulses during RUN (k+5, k+23) must be ignored
        fork
            do_mac(8'h13, 8'h9C, 8'h05, res, lat);
            begin
                @(posedge clk_i);
                #1;
                repeat (4) @(posedge clk_i);
                #1;
                mac.mul_start_strb = 1'b1;
                mac.a   = 8'hAA;
                mac.b   = 8'h55;
                mac.acc = 8'h3C;
                @(posedge clk_i);
                #1;
                mac.mul_start_strb = 1'b0;
                repeat (17) @(posedge clk_i);
                #1;
                mac.mul_start_strb = 1'b1;
                @(posedge clk_i);
                #1;
                mac.mul_start_strb = 1'b0;
            end
        join
        check("t4_lat", 32'(lat), 32'(CDM * W));
        check("t4_out", 32'(res), 32'(model(8'h13, 8'h9C, 8'h05)));

        // Five back-to-back chained MACs, feedback of the previous result
        chain = model(8'h13, 8'h9C, 8'h05);
        for (int i = 0; i < 5; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            do_mac(ra, rb, chain, res, lat);
            chain = model(ra, rb, chain);
            check($sformatf("t4_chain%0d_lat", i), 32'(lat), 32'(exp_lat(rb)));
            check($sformatf("t4_chain%0d_out", i), 32'(res), 32'(chain));
        end

        // Reset mid-operation at k+10: no done, out cleared
        @(posedge clk_i);
        #1;
        mac.mul_start_strb = 1'b1;
        mac.a   = 8'h21;
        mac.b   = 8'h83;
        mac.acc = 8'h10;
        @(posedge clk_i);
        #1;
        mac.mul_start_strb = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("t5_out_cleared", 32'(mac.out), 32'd0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (mac.mul_done_strb === 1'b1) seen++;
            @(posedge clk_i);
            #1;
        end
        check("t5_no_done", 32'(seen), 32'd0);
        run_check("t5_fresh", 8'h21, 8'h83, 8'h10);

        // Early-termination latency corner cases (full latency otherwise)
        run_check("t6b", 8'd6, 8'd5, 8'd1);
        run_check("t6c", 8'd6, 8'hFB, 8'd1);

        // Randomized operations with random idle gaps
        for (int i = 0; i < 25; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            racc = W'($urandom);
            if (i % 7 == 0) rb = W'($urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) @(posedge clk_i);
            #1;
            do_mac(ra, rb, racc, res, lat);
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(exp_lat(rb)));
            check($sformatf("rnd%0d_out", i), 32'(res), 32'(model(ra, rb, racc)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule : tb_serial_mac_unit
